// File: rtl/interface_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 front-end: state codes, default timing
// parameters, BCD widths and the saturating BCD increment.
package interface_hcsr04_pkg;

    localparam int TRIGGER_CICLOS_DEF = 500;        // 10 us at 50 MHz
    localparam int CICLOS_POR_CM_DEF  = 2941;       // 58.82 us at 50 MHz
    localparam int TIMEOUT_CICLOS_DEF = 2_000_000;  // 40 ms at 50 MHz

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_W       = 3 * BCD_DIGIT_W;

    typedef logic [BCD_W-1:0] bcd3_t;

    typedef enum logic [3:0] {
        ST_INICIAL       = 4'h0,
        ST_PREPARACAO    = 4'h1,
        ST_ENVIA_TRIGGER = 4'h2,
        ST_ESPERA_ECHO   = 4'h3,
        ST_MEDIDA        = 4'h4,
        ST_ARMAZENAMENTO = 4'h5,
        ST_FINAL_MEDIDA  = 4'h6,
        ST_ERRO          = 4'hE
    } estado_t;

    // Adds one to a 3-digit BCD value with decimal carry; 999 stays 999.
    function automatic bcd3_t bcd_inc_sat(input bcd3_t v);
        bcd3_t r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/interface_hcsr04_if.sv
// Sensor-side and control-unit-side signals of the HC-SR04 front-end.
interface interface_hcsr04_if;
    import interface_hcsr04_pkg::*;

    logic        medir;
    logic        echo;
    logic        trigger;
    bcd3_t       medida;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    // Driver of requests / sensor echo (control unit + sensor side).
    modport master (
        output medir, echo,
        input  trigger, medida, pronto, erro, db_estado
    );

    // The measurement front-end itself.
    modport slave (
        input  medir, echo,
        output trigger, medida, pronto, erro, db_estado
    );

endinterface

// File: rtl/interface_hcsr04_contador_cm.sv
// Echo-width to centimetre converter: divisor counter feeding a saturating
// 3-digit BCD accumulator, with round-half-up on the leftover remainder.
module interface_hcsr04_contador_cm
    import interface_hcsr04_pkg::*;
#(
    parameter int CICLOS_POR_CM = CICLOS_POR_CM_DEF
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  zera_i,
    input  logic  conta_i,
    output bcd3_t resultado_o
);

    localparam int DIV_W = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CICLOS_POR_CM - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CICLOS_POR_CM / 2);

    logic [DIV_W-1:0] div_q, div_d;
    bcd3_t            acc_q, acc_d;
    logic             arredonda;

    // Next-state: clear on zera, otherwise advance divisor and carry into BCD.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        div_d = div_q;
        acc_d = acc_q;
        if (zera_i) begin
            div_d = '0;
            acc_d = '0;
        end else if (conta_i) begin
            if (div_q == DIV_MAX) begin
                div_d = '0;
                acc_d = bcd_inc_sat(acc_q);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Divisor and accumulator registers.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            div_q <= '0;
            acc_q <= '0;
        end else begin
            div_q <= div_d;
            acc_q <= acc_d;
        end
    end

    // Remainder of at least half a centimetre rounds the result up.
    assign arredonda   = (CICLOS_POR_CM > 1) && (div_q >= DIV_HALF);
    assign resultado_o = arredonda ? bcd_inc_sat(acc_q) : acc_q;

endmodule

// File: rtl/interface_hcsr04.sv
// HC-SR04 measurement front-end: trigger generation, echo timing with
// timeout, BCD distance result and completion/error reporting.
module interface_hcsr04
    import interface_hcsr04_pkg::*;
#(
    parameter int TRIGGER_CICLOS = TRIGGER_CICLOS_DEF,
    parameter int CICLOS_POR_CM  = CICLOS_POR_CM_DEF,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    interface_hcsr04_if.slave    bus
);

    localparam int TRIG_W = $clog2(TRIGGER_CICLOS + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CICLOS + 1);

    estado_t           state_q, state_d;
    logic              echo_meta_q, echo_s_q;
    logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    bcd3_t             medida_q, medida_d;
    logic              erro_q, erro_d;
    logic              zera, conta, timeout_hit;
    bcd3_t             resultado;
    logic [3:0]        db_estado;

    interface_hcsr04_contador_cm #(
        .CICLOS_POR_CM (CICLOS_POR_CM)
    ) u_contador_cm (
        .clock       (clock),
        .reset       (reset),
        .zera_i      (zera),
        .conta_i     (conta),
        .resultado_o (resultado)
    );

    // Two-flop synchroniser for the asynchronous echo line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            echo_meta_q <= bus.echo;
            echo_s_q    <= echo_meta_q;
        end
    end

    // Next-state and datapath control for the measurement sequence.
    always_comb begin
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        timeout_d  = timeout_q;
        medida_d   = medida_q;
        erro_d     = erro_q;
        zera       = 1'b0;
        conta      = 1'b0;
        // Last allowed cycle waiting for / timing the echo.
        timeout_hit = (timeout_q == TO_W'(TIMEOUT_CICLOS - 1));

        case (state_q)
            ST_INICIAL: begin
                if (bus.medir) state_d = ST_PREPARACAO;
            end
            ST_PREPARACAO: begin
                trig_cnt_d = '0;
                timeout_d  = '0;
                erro_d     = 1'b0;
                zera       = 1'b1;
                state_d    = ST_ENVIA_TRIGGER;
            end
            ST_ENVIA_TRIGGER: begin
                if (trig_cnt_q == TRIG_W'(TRIGGER_CICLOS - 1)) begin
                    state_d = ST_ESPERA_ECHO;
                end else begin
                    trig_cnt_d = trig_cnt_q + TRIG_W'(1);
                end
            end
            ST_ESPERA_ECHO: begin
                timeout_d = timeout_q + TO_W'(1);
                if (timeout_hit) begin
                    erro_d  = 1'b1;
                    state_d = ST_ERRO;
                end else if (echo_s_q) begin
                    // The rising-edge cycle is already part of the echo width.
                    conta   = 1'b1;
                    state_d = ST_MEDIDA;
                end
            end
            ST_MEDIDA: begin
                timeout_d = timeout_q + TO_W'(1);
                if (timeout_hit) begin
                    erro_d  = 1'b1;
                    state_d = ST_ERRO;
                end else if (echo_s_q) begin
                    conta = 1'b1;
                end else begin
                    state_d = ST_ARMAZENAMENTO;
                end
            end
            ST_ARMAZENAMENTO: begin
                medida_d = resultado;
                state_d  = ST_FINAL_MEDIDA;
            end
            ST_FINAL_MEDIDA: state_d = ST_INICIAL;
            ST_ERRO:         state_d = ST_INICIAL;
            default:         state_d = ST_INICIAL;
        endcase
    end

    // State, counters and held output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INICIAL;
            trig_cnt_q <= '0;
            timeout_q  <= '0;
            medida_q   <= '0;
            erro_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_cnt_q <= trig_cnt_d;
            timeout_q  <= timeout_d;
            medida_q   <= medida_d;
            erro_q     <= erro_d;
        end
    end

    // Debug state code; anything outside the legal set reads as 0xF.
    always_comb begin
        db_estado = 4'hF;
        case (state_q)
            ST_INICIAL, ST_PREPARACAO, ST_ENVIA_TRIGGER, ST_ESPERA_ECHO,
            ST_MEDIDA, ST_ARMAZENAMENTO, ST_FINAL_MEDIDA, ST_ERRO:
                db_estado = state_q;
            default: db_estado = 4'hF;
        endcase
    end

    assign bus.trigger   = (state_q == ST_ENVIA_TRIGGER);
    assign bus.pronto    = (state_q == ST_FINAL_MEDIDA) || (state_q == ST_ERRO);
    assign bus.medida    = medida_q;
    assign bus.erro      = erro_q;
    assign bus.db_estado = db_estado;

endmodule
